// File: rtl/vcve2_pkg.sv
// Shared types for the vector configuration unit: vtype layout, CSR numbers,
// CSR operation encoding, configuration FSM states and the CSR write helper.
package vcve2_pkg;

  typedef enum logic [1:0] {
    CSR_OP_READ  = 2'd0,
    CSR_OP_WRITE = 2'd1,
    CSR_OP_SET   = 2'd2,
    CSR_OP_CLEAR = 2'd3
  } csr_op_e;

  typedef enum logic [11:0] {
    CSR_VSTART = 12'h008,
    CSR_VXSAT  = 12'h009,
    CSR_VXRM   = 12'h00A,
    CSR_VCSR   = 12'h00F,
    CSR_VL     = 12'hC20,
    CSR_VTYPE  = 12'hC21,
    CSR_VLENB  = 12'hC22
  } csr_num_e;

  // Encodings 1xx are reserved and always exceed ELEN.
  typedef enum logic [2:0] {
    VSEW_8  = 3'b000,
    VSEW_16 = 3'b001,
    VSEW_32 = 3'b010,
    VSEW_64 = 3'b011
  } vsew_e;

  typedef enum logic [2:0] {
    LMUL_1    = 3'b000,
    LMUL_2    = 3'b001,
    LMUL_4    = 3'b010,
    LMUL_8    = 3'b011,
    LMUL_RSVD = 3'b100,
    LMUL_F8   = 3'b101,
    LMUL_F4   = 3'b110,
    LMUL_F2   = 3'b111
  } vlmul_e;

  typedef struct packed {
    logic        vill;
    logic [22:0] reserved;
    logic        vma;
    logic        vta;
    vsew_e       vsew;
    vlmul_e      vlmul;
  } vtype_t;

  localparam logic [31:0] VTYPE_VILL_RESET = 32'h8000_0000;

  typedef enum logic [1:0] {
    CFG_IDLE   = 2'd0,
    CFG_DRAIN  = 2'd1,
    CFG_UPDATE = 2'd2,
    CFG_RESP   = 2'd3
  } cfg_state_e;

  // Value a CSR instruction leaves in the register, given the old contents.
  function automatic logic [31:0] csr_wval(input csr_op_e op, input logic [31:0] old,
                                           input logic [31:0] wdata);
    case (op)
      CSR_OP_WRITE: return wdata;
      CSR_OP_SET:   return old | wdata;
      CSR_OP_CLEAR: return old & ~wdata;
      default:      return old;
    endcase
  endfunction

endpackage

// File: rtl/vcve2_vlmax.sv
// Combinational vtype legality check and VLMAX = VLEN*LMUL/SEW, done in the
// log2 domain so only a single shift is needed.
module vcve2_vlmax
  import vcve2_pkg::*;
#(
  parameter int VLEN = 128,
  parameter int ELEN = 32,
  parameter int AvlW = 32
) (
  input  vtype_t            vtype,
  output logic              illegal,
  output logic [AvlW-1:0]   vlmax
);

  localparam logic signed [5:0] LogVlen = 6'($clog2(VLEN));
  localparam logic signed [5:0] LogElen = 6'($clog2(ELEN));

  logic signed [5:0] lmul_log2, sew_log2, exp_log2;
  logic              unused_bits;

  // vill/vma/vta do not affect VLMAX or legality of the request
  assign unused_bits = ^{vtype.vill, vtype.vma, vtype.vta};

  // Derive log2(LMUL), log2(SEW) and log2(VLMAX), then legality and VLMAX
  always_comb begin
    case (vtype.vlmul)
      LMUL_2:  lmul_log2 = 6'sd1;
      LMUL_4:  lmul_log2 = 6'sd2;
      LMUL_8:  lmul_log2 = 6'sd3;
      LMUL_F2: lmul_log2 = -6'sd1;
      LMUL_F4: lmul_log2 = -6'sd2;
      LMUL_F8: lmul_log2 = -6'sd3;
      default: lmul_log2 = 6'sd0;
    endcase
    sew_log2 = 6'sd3 + $signed({3'b000, vtype.vsew});
    exp_log2 = LogVlen + lmul_log2 - sew_log2;
    illegal  = (vtype.vlmul == LMUL_RSVD)
             | (|vtype.reserved)
             | (sew_log2 > LogElen)
             | (lmul_log2 + LogElen < sew_log2)
             | (exp_log2 < 6'sd0);
    vlmax    = illegal ? '0 : (AvlW'(1) << exp_log2[4:0]);
  end

endmodule

// File: rtl/vcve2_vcfg_unit.sv
// Vector configuration state unit: holds vtype/vl/vstart (and vxrm/vxsat),
// executes vset* behind a drain of the vector unit, serves vector CSRs.
// Build option: define VCVE2_VCFG_FIXPOINT_EN to implement vxsat/vxrm/vcsr.
module vcve2_vcfg_unit
  import vcve2_pkg::*;
#(
  parameter int VLEN = 128,
  parameter int ELEN = 32,
  parameter int AvlW = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     cfg_valid_i,
  output logic                     cfg_ready_o,
  input  logic [AvlW-1:0]          cfg_avl_i,
  input  logic [31:0]              cfg_vtype_i,
  input  logic                     cfg_rs1_zero_i,
  input  logic                     cfg_rd_zero_i,
  input  logic                     cfg_flush_i,
  output logic                     cfg_rvalid_o,
  input  logic                     cfg_rready_i,
  output logic [AvlW-1:0]          cfg_vl_o,
  input  logic                     vu_idle_i,
  output logic [31:0]              vu_vtype_o,
  output logic [AvlW-1:0]          vu_vl_o,
  output logic [$clog2(VLEN)-1:0]  vu_vstart_o,
  output logic [1:0]               vu_vxrm_o,
  input  logic                     vstart_we_i,
  input  logic [$clog2(VLEN)-1:0]  vstart_i,
  input  logic                     vxsat_set_i,
  input  logic                     csr_access_i,
  input  logic [11:0]              csr_addr_i,
  input  csr_op_e                  csr_op_i,
  input  logic [31:0]              csr_wdata_i,
  output logic [31:0]              csr_rdata_o,
  output logic                     csr_illegal_o,
  output logic                     csr_busy_o
);

  localparam int VsW = $clog2(VLEN);

  cfg_state_e       state, state_n;
  logic [AvlW-1:0]  req_avl;
  vtype_t           req_vtype;
  logic             req_rs1_zero, req_rd_zero;
  vtype_t           vtype_q, vtype_new;
  logic [AvlW-1:0]  vl_q, vl_new, resp_vl, vlmax;
  logic [VsW-1:0]   vstart_q;
  logic             vt_illegal;
  logic [31:0]      rdata_raw, wval;
  logic             csr_known, csr_ro, wr_req, csr_wr_en, we_vstart;
  logic             unused_csr;
`ifdef VCVE2_VCFG_FIXPOINT_EN
  logic [1:0]       vxrm_q;
  logic             vxsat_q;
  logic             we_vxsat, we_vxrm, we_vcsr;
`else
  logic             unused_sat;
`endif

  vcve2_vlmax #(
    .VLEN (VLEN),
    .ELEN (ELEN),
    .AvlW (AvlW)
  ) u_vlmax (
    .vtype   (req_vtype),
    .illegal (vt_illegal),
    .vlmax   (vlmax)
  );

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= CFG_IDLE;
    else         state <= state_n;
  end

  // FSM next state: accept, wait for drain (or flush), commit, respond
  always_comb begin
    state_n = state;
    case (state)
      CFG_IDLE:   if (cfg_valid_i) state_n = CFG_DRAIN;
      CFG_DRAIN:  if (cfg_flush_i) state_n = CFG_IDLE;
                  else if (vu_idle_i) state_n = CFG_UPDATE;
      CFG_UPDATE: state_n = CFG_RESP;
      CFG_RESP:   if (cfg_flush_i || cfg_rready_i) state_n = CFG_IDLE;
      default:    state_n = CFG_IDLE;
    endcase
  end

  // FSM outputs; a flush in RESP hides the response the same cycle it drops it
  always_comb begin
    cfg_ready_o  = (state == CFG_IDLE);
    cfg_rvalid_o = (state == CFG_RESP) && !cfg_flush_i;
    csr_busy_o   = (state != CFG_IDLE);
  end

  // Latch the vset* operands when the request is accepted
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_avl      <= '0;
      req_vtype    <= '0;
      req_rs1_zero <= 1'b0;
      req_rd_zero  <= 1'b0;
    end else if (state == CFG_IDLE && cfg_valid_i) begin
      req_avl      <= cfg_avl_i;
      req_vtype    <= vtype_t'(cfg_vtype_i);
      req_rs1_zero <= cfg_rs1_zero_i;
      req_rd_zero  <= cfg_rd_zero_i;
    end
  end

  // New vl from the AVL rules; an illegal vtype forces vl to zero
  always_comb begin
    if (vt_illegal)                         vl_new = '0;
    else if (req_rs1_zero && !req_rd_zero)  vl_new = vlmax;
    else if (req_rs1_zero)                  vl_new = (vl_q < vlmax) ? vl_q : vlmax;
    else                                    vl_new = (req_avl < vlmax) ? req_avl : vlmax;
  end

  assign vtype_new = vt_illegal ? vtype_t'(VTYPE_VILL_RESET)
                                : vtype_t'({1'b0, req_vtype[30:0]});

  // Commit vtype/vl and capture the response value in UPDATE
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vtype_q <= vtype_t'(VTYPE_VILL_RESET);
      vl_q    <= '0;
      resp_vl <= '0;
    end else if (state == CFG_UPDATE) begin
      vtype_q <= vtype_new;
      vl_q    <= vl_new;
      resp_vl <= vl_new;
    end
  end

  // CSR read mux and address decode
  always_comb begin
    rdata_raw = '0;
    csr_known = 1'b1;
    csr_ro    = 1'b0;
    case (csr_addr_i)
      CSR_VSTART: rdata_raw = 32'(vstart_q);
`ifdef VCVE2_VCFG_FIXPOINT_EN
      CSR_VXSAT:  rdata_raw = {31'b0, vxsat_q};
      CSR_VXRM:   rdata_raw = {30'b0, vxrm_q};
      CSR_VCSR:   rdata_raw = {29'b0, vxrm_q, vxsat_q};
`endif
      CSR_VL:     begin rdata_raw = 32'(vl_q);      csr_ro = 1'b1; end
      CSR_VTYPE:  begin rdata_raw = vtype_q;        csr_ro = 1'b1; end
      CSR_VLENB:  begin rdata_raw = 32'(VLEN / 8);  csr_ro = 1'b1; end
      default:    csr_known = 1'b0;
    endcase
  end

  // Set/clear with a zero mask is a pure read and never counts as a write
  assign wr_req        = (csr_op_i == CSR_OP_WRITE)
                       | (((csr_op_i == CSR_OP_SET) | (csr_op_i == CSR_OP_CLEAR)) & (|csr_wdata_i));
  assign csr_illegal_o = csr_access_i & (~csr_known | (csr_ro & wr_req));
  assign csr_rdata_o   = csr_access_i ? rdata_raw : '0;
  assign csr_wr_en     = csr_access_i & csr_known & ~csr_ro & wr_req & (state == CFG_IDLE);
  assign wval          = csr_wval(csr_op_i, rdata_raw, csr_wdata_i);
  assign we_vstart     = csr_wr_en & (csr_addr_i == CSR_VSTART);
  assign unused_csr    = ^wval;

  // vstart: UPDATE clear beats CSR write, which beats the vector unit write
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                  vstart_q <= '0;
    else if (state == CFG_UPDATE) vstart_q <= '0;
    else if (we_vstart)           vstart_q <= wval[VsW-1:0];
    else if (vstart_we_i)         vstart_q <= vstart_i;
  end

`ifdef VCVE2_VCFG_FIXPOINT_EN
  assign we_vxsat = csr_wr_en & (csr_addr_i == CSR_VXSAT);
  assign we_vxrm  = csr_wr_en & (csr_addr_i == CSR_VXRM);
  assign we_vcsr  = csr_wr_en & (csr_addr_i == CSR_VCSR);

  // Fixed-point state; a saturation event is ORed in after any CSR write
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vxrm_q  <= 2'b00;
      vxsat_q <= 1'b0;
    end else begin
      if (we_vxrm)      vxrm_q <= wval[1:0];
      else if (we_vcsr) vxrm_q <= wval[2:1];
      vxsat_q <= ((we_vxsat || we_vcsr) ? wval[0] : vxsat_q) | vxsat_set_i;
    end
  end

  assign vu_vxrm_o = vxrm_q;
`else
  assign unused_sat = vxsat_set_i;
  assign vu_vxrm_o  = 2'b00;
`endif

  assign cfg_vl_o    = resp_vl;
  assign vu_vtype_o  = vtype_q;
  assign vu_vl_o     = vl_q;
  assign vu_vstart_o = vstart_q;

endmodule

// File: tb/tb_vcve2_vcfg_unit.sv
// Scoreboard bench for vcve2_vcfg_unit (VLEN=128, ELEN=32): vset* responses
// are predicted by an arithmetic reference model and checked by a monitor.
module tb_vcve2_vcfg_unit;
  import vcve2_pkg::*;

  localparam int VLEN = 128;
  localparam int ELEN = 32;
  localparam int AvlW = 32;
  localparam int VsW  = 7;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_valid = 0, cfg_rs1_zero = 0, cfg_rd_zero = 0, cfg_flush = 0;
  logic              cfg_rready = 1, vu_idle = 1, vstart_we = 0, vxsat_set = 0, csr_access = 0;
  logic [AvlW-1:0]   cfg_avl = '0;
  logic [31:0]       cfg_vtype = '0, csr_wdata = '0;
  logic [VsW-1:0]    vstart_in = '0;
  logic [11:0]       csr_addr = '0;
  csr_op_e           csr_op = CSR_OP_READ;
  logic              cfg_ready, cfg_rvalid, csr_illegal, csr_busy;
  logic [AvlW-1:0]   cfg_vl, vu_vl;
  logic [31:0]       vu_vtype, csr_rdata;
  logic [VsW-1:0]    vu_vstart;
  logic [1:0]        vu_vxrm;

  always #5 clk = ~clk;

  vcve2_vcfg_unit #(.VLEN(VLEN), .ELEN(ELEN), .AvlW(AvlW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready), .cfg_avl_i(cfg_avl),
    .cfg_vtype_i(cfg_vtype), .cfg_rs1_zero_i(cfg_rs1_zero), .cfg_rd_zero_i(cfg_rd_zero),
    .cfg_flush_i(cfg_flush), .cfg_rvalid_o(cfg_rvalid), .cfg_rready_i(cfg_rready),
    .cfg_vl_o(cfg_vl), .vu_idle_i(vu_idle), .vu_vtype_o(vu_vtype), .vu_vl_o(vu_vl),
    .vu_vstart_o(vu_vstart), .vu_vxrm_o(vu_vxrm), .vstart_we_i(vstart_we),
    .vstart_i(vstart_in), .vxsat_set_i(vxsat_set), .csr_access_i(csr_access),
    .csr_addr_i(csr_addr), .csr_op_i(csr_op), .csr_wdata_i(csr_wdata),
    .csr_rdata_o(csr_rdata), .csr_illegal_o(csr_illegal), .csr_busy_o(csr_busy)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] vl;
    logic [31:0] vt;
    int          first;
    int          done;
  } exp_t;
  exp_t exp_q[$];

  // architectural model state
  logic [31:0] m_vl = 0, m_vt = 32'h8000_0000, m_vstart = 0;
  logic [31:0] m_vxsat = 0, m_vxrm = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference vset*: SEW/LMUL as plain numbers, VLMAX by real division
  function automatic void ref_vset(input logic [31:0] avl, input logic [31:0] vt,
                                   input logic [31:0] oldvl, input bit rs1z, input bit rdz,
                                   output logic [31:0] nvl, output logic [31:0] nvt);
    int sew, lnum, lden, vmax;
    bit ill;
    ill = 0; lnum = 1; lden = 1;
    sew = 8 << vt[5:3];
    case (vt[2:0])
      3'd0: lnum = 1;
      3'd1: lnum = 2;
      3'd2: lnum = 4;
      3'd3: lnum = 8;
      3'd4: ill = 1;
      3'd5: lden = 8;
      3'd6: lden = 4;
      default: lden = 2;
    endcase
    if (vt[30:8] != 0) ill = 1;
    if (sew > ELEN) ill = 1;
    if (lnum * ELEN < sew * lden) ill = 1;
    vmax = (VLEN * lnum) / (lden * sew);
    if (vmax == 0) ill = 1;
    if (ill) begin
      nvt = 32'h8000_0000;
      nvl = 0;
    end else begin
      nvt = {1'b0, vt[30:0]};
      if (rs1z && !rdz)  nvl = vmax;
      else if (rs1z)     nvl = (oldvl < vmax) ? oldvl : vmax;
      else               nvl = (avl < vmax) ? avl : vmax;
    end
  endfunction

  // Monitor: compares every presented response against the scoreboard head
  always begin
    @(negedge clk);
    #2;
    if (rst_n && cfg_rvalid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rvalid: got vl=%0d with no request pending (cycle %0d)", cfg_vl, cyc);
      end else begin
        chk("resp_vl", cfg_vl, exp_q[0].vl);
        chk("ready_low_in_resp", {31'b0, cfg_ready}, 0);
        chk("rvalid_not_early", {31'b0, (cyc >= exp_q[0].first)}, 1);
        if (cfg_rready) begin
          chk("resp_cycle", cyc, exp_q[0].done);
          chk("vu_vtype", vu_vtype, exp_q[0].vt);
          chk("vu_vl", vu_vl, exp_q[0].vl);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // One vset* transaction; dly = cycles vu_idle stays low, rdly = rready stall
  task automatic do_cfg(input logic [31:0] avl, input logic [31:0] vt, input bit rs1z,
                        input bit rdz, input int dly, input int rdly, input bit flush);
    exp_t e;
    int   c0;
    bit   done;
    logic [31:0] busy_wd;
    @(negedge clk);
    c0 = cyc;
    cfg_valid = 1; cfg_avl = avl; cfg_vtype = vt; cfg_rs1_zero = rs1z; cfg_rd_zero = rdz;
    vu_idle = (dly == 0); cfg_rready = 0;
    chk("ready_idle", {31'b0, cfg_ready}, 1);
    if (!flush) begin
      ref_vset(avl, vt, m_vl, rs1z, rdz, e.vl, e.vt);
      e.first = c0 + 3 + dly;
      e.done  = c0 + 3 + dly + rdly;
      exp_q.push_back(e);
      m_vl = e.vl; m_vt = e.vt; m_vstart = 0;
    end
    done = 0;
    busy_wd = $urandom;
    for (int k = 1; k < 80; k++) begin
      @(negedge clk);
      cfg_valid  = 0;
      vu_idle    = (k >= 1 + dly);
      cfg_flush  = flush && (k == 2);
      cfg_rready = (k >= 3 + dly + rdly);
      csr_access = 0;
      if (flush && k == 1) begin
        csr_access = 1; csr_addr = CSR_VSTART; csr_op = CSR_OP_WRITE; csr_wdata = busy_wd;
        #1;
        chk("busy_in_drain", {31'b0, csr_busy}, 1);
        chk("rdata_while_busy", csr_rdata, m_vstart);
      end
      if (flush ? (k >= dly + 6) : (exp_q.size() == 0)) begin
        done = 1;
        break;
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL cfg_timeout: got no response, required one within 80 cycles (start %0d)", c0);
      exp_q.delete();
    end
    cfg_flush = 0; cfg_rready = 1; vu_idle = 1; csr_access = 0;
  endtask

  task automatic csr_rd(input logic [11:0] a, input logic [31:0] e, input string nm);
    @(negedge clk);
    csr_access = 1; csr_addr = a; csr_op = CSR_OP_READ; csr_wdata = 0;
    #1;
    chk(nm, csr_rdata, e);
    chk({nm, "_legal"}, {31'b0, csr_illegal}, 0);
    csr_access = 0;
  endtask

  // CSR access held over one clock edge, with optional side-band events
  task automatic csr_wr(input logic [11:0] a, input csr_op_e op, input logic [31:0] wd,
                        input bit e_ill, input bit sat, input bit vswe,
                        input logic [VsW-1:0] vsv, input string nm);
    @(negedge clk);
    csr_access = 1; csr_addr = a; csr_op = op; csr_wdata = wd;
    vxsat_set = sat; vstart_we = vswe; vstart_in = vsv;
    #1;
    chk(nm, {31'b0, csr_illegal}, {31'b0, e_ill});
    @(negedge clk);
    csr_access = 0; vxsat_set = 0; vstart_we = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish, required one within 400us");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    logic [31:0] vt, avl, wd;
    bit rs1z, rdz, fl, vswe;
    int dly, rdly;
    logic [VsW-1:0] vsv;

    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, cfg_ready}, 1);
    chk("rst_rvalid", {31'b0, cfg_rvalid}, 0);
    chk("rst_vtype", vu_vtype, 32'h8000_0000);
    chk("rst_vl", vu_vl, 0);
    chk("rst_vstart", {25'b0, vu_vstart}, 0);
    chk("rst_busy", {31'b0, csr_busy}, 0);
    chk("rst_cfg_vl", cfg_vl, 0);
    chk("rst_vxrm", {30'b0, vu_vxrm}, 0);
    rst_n = 1;

    csr_rd(CSR_VTYPE, 32'h8000_0000, "rd_vtype_rst");
    csr_rd(CSR_VL, 0, "rd_vl_rst");
    csr_rd(CSR_VLENB, 16, "rd_vlenb");
    csr_rd(CSR_VSTART, 0, "rd_vstart_rst");

    // directed vset* cases
    do_cfg(10, 32'h010, 0, 0, 0, 0, 0);
    do_cfg(10, 32'h018, 0, 0, 0, 0, 0);
    do_cfg(10, 32'h005, 0, 0, 0, 0, 0);
    do_cfg(10, 32'h006, 0, 0, 0, 0, 0);
    do_cfg(0, 32'h003, 1, 0, 0, 0, 0);
    do_cfg(0, 32'h010, 1, 1, 0, 0, 0);
    do_cfg(7, 32'h010, 0, 0, 5, 0, 0);
    do_cfg(100, 32'h00A, 0, 0, 1, 3, 0);
    csr_rd(CSR_VL, m_vl, "rd_vl_after_cfg");
    csr_rd(CSR_VTYPE, m_vt, "rd_vtype_after_cfg");

    // flush in DRAIN leaves everything untouched, busy write ignored
    csr_wr(CSR_VSTART, CSR_OP_WRITE, 32'h0A, 0, 0, 0, 0, "wr_vstart_a");
    m_vstart = 32'h0A;
    do_cfg(3, 32'h008, 0, 0, 5, 0, 1);
    chk("flush_vl", vu_vl, m_vl);
    chk("flush_vtype", vu_vtype, m_vt);
    chk("flush_vstart", {25'b0, vu_vstart}, m_vstart);
    chk("flush_ready", {31'b0, cfg_ready}, 1);
    do_cfg(5, 32'h008, 0, 0, 0, 0, 0);
    csr_rd(CSR_VSTART, 0, "rd_vstart_cleared");

    // read-only and unknown CSRs
    csr_wr(CSR_VL, CSR_OP_WRITE, 5, 1, 0, 0, 0, "ill_wr_vl");
    csr_wr(CSR_VL, CSR_OP_SET, 0, 0, 0, 0, 0, "set0_vl");
    csr_wr(CSR_VTYPE, CSR_OP_CLEAR, 1, 1, 0, 0, 0, "ill_clr_vtype");
    csr_wr(CSR_VLENB, CSR_OP_SET, 4, 1, 0, 0, 0, "ill_set_vlenb");
    csr_wr(12'h123, CSR_OP_READ, 0, 1, 0, 0, 0, "ill_unknown");
    csr_rd(CSR_VL, m_vl, "rd_vl_unchanged");

    // vstart truncation and write priority
    csr_wr(CSR_VSTART, CSR_OP_WRITE, 32'h1FF, 0, 0, 0, 0, "wr_vstart_1ff");
    csr_rd(CSR_VSTART, 32'h7F, "rd_vstart_trunc");
    csr_wr(CSR_VSTART, CSR_OP_WRITE, 32'h11, 0, 0, 1, 7'h22, "wr_vstart_vs_we");
    csr_rd(CSR_VSTART, 32'h11, "rd_vstart_csr_wins");
    csr_wr(CSR_VSTART, CSR_OP_READ, 0, 0, 0, 1, 7'h22, "rd_with_we");
    csr_rd(CSR_VSTART, 32'h22, "rd_vstart_we");
    csr_wr(CSR_VSTART, CSR_OP_SET, 32'h40, 0, 0, 0, 0, "set_vstart");
    csr_rd(CSR_VSTART, 32'h62, "rd_vstart_set");
    csr_wr(CSR_VSTART, CSR_OP_CLEAR, 32'h02, 0, 0, 0, 0, "clr_vstart");
    csr_rd(CSR_VSTART, 32'h60, "rd_vstart_clr");
    m_vstart = 32'h60;

`ifdef VCVE2_VCFG_FIXPOINT_EN
    csr_wr(CSR_VXSAT, CSR_OP_WRITE, 0, 0, 1, 0, 0, "wr_vxsat_sat");
    csr_rd(CSR_VXSAT, 1, "rd_vxsat_kept");
    csr_wr(CSR_VXRM, CSR_OP_WRITE, 3, 0, 0, 0, 0, "wr_vxrm");
    csr_rd(CSR_VXRM, 3, "rd_vxrm");
    csr_wr(CSR_VCSR, CSR_OP_WRITE, 4, 0, 0, 0, 0, "wr_vcsr");
    csr_rd(CSR_VCSR, 4, "rd_vcsr");
    csr_rd(CSR_VXSAT, 0, "rd_vxsat_cleared");
    chk("vu_vxrm", {30'b0, vu_vxrm}, 2);
    csr_wr(CSR_VL, CSR_OP_READ, 0, 0, 1, 0, 0, "sat_only");
    csr_rd(CSR_VXSAT, 1, "rd_vxsat_set");
`else
    csr_wr(CSR_VXSAT, CSR_OP_WRITE, 0, 1, 1, 0, 0, "ill_vxsat");
    csr_wr(CSR_VXRM, CSR_OP_READ, 0, 1, 0, 0, 0, "ill_vxrm");
    csr_wr(CSR_VCSR, CSR_OP_WRITE, 6, 1, 0, 0, 0, "ill_vcsr");
    chk("vu_vxrm_tied", {30'b0, vu_vxrm}, 0);
`endif

    // randomized vset* traffic mixed with vstart activity
    for (int i = 0; i < 40; i++) begin
      vt = {24'b0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))};
      if ($urandom_range(0, 7) == 0) vt[$urandom_range(8, 30)] = 1'b1;
      avl  = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 200);
      rs1z = 1'($urandom_range(0, 1));
      rdz  = 1'($urandom_range(0, 1));
      fl   = ($urandom_range(0, 7) == 0);
      dly  = fl ? 3 : $urandom_range(0, 3);
      rdly = $urandom_range(0, 2);
      do_cfg(avl, vt, rs1z, rdz, dly, rdly, fl);
      csr_rd(CSR_VL, m_vl, "rnd_vl");
      csr_rd(CSR_VTYPE, m_vt, "rnd_vtype");
      wd   = $urandom;
      vswe = 1'($urandom_range(0, 1));
      vsv  = 7'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        csr_wr(CSR_VSTART, CSR_OP_WRITE, wd, 0, 0, vswe, vsv, "rnd_wr_vstart");
        m_vstart = {25'b0, wd[6:0]};
      end else begin
        csr_wr(CSR_VSTART, CSR_OP_READ, 0, 0, 0, vswe, vsv, "rnd_rd_vstart");
        if (vswe) m_vstart = {25'b0, vsv};
      end
      csr_rd(CSR_VSTART, m_vstart, "rnd_vstart");
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
